// File: rtl/pa_fpu_special_pipe_if.sv
// Handshake/data bundle between the EX1 issue logic and the FPU special-result pipe.
interface pa_fpu_special_pipe_if #(parameter int FLEN = 32);
    logic            ex1_inst_vld;
    logic            pipe_stall;
    logic            pipe_flush;
    logic            ex1_double;
    logic [FLEN-1:0] ex1_srcf0;
    logic [FLEN-1:0] ex1_srcf1;
    logic [FLEN-1:0] ex1_srcf2;
    logic [1:0]      ex1_src_idx;
    logic [6:0]      ex1_special_sel;
    logic [3:0]      ex1_special_sign;
    logic [4:0]      ex1_fflags;
    logic            acc_clr;
    logic            out_vld;
    logic            out_wb;
    logic [FLEN-1:0] out_data;
    logic [4:0]      out_fflags;
    logic [4:0]      acc_fflags;

    modport master (
        output ex1_inst_vld, pipe_stall, pipe_flush, ex1_double, ex1_srcf0, ex1_srcf1,
               ex1_srcf2, ex1_src_idx, ex1_special_sel, ex1_special_sign, ex1_fflags, acc_clr,
        input  out_vld, out_wb, out_data, out_fflags, acc_fflags
    );

    modport slave (
        input  ex1_inst_vld, pipe_stall, pipe_flush, ex1_double, ex1_srcf0, ex1_srcf1,
               ex1_srcf2, ex1_src_idx, ex1_special_sel, ex1_special_sign, ex1_fflags, acc_clr,
        output out_vld, out_wb, out_data, out_fflags, acc_fflags
    );
endinterface

// File: rtl/pa_fpu_special_pipe.sv
// FPU special-value pipe: carries EX1 operands DEPTH stages, then forms the special result
// (signed zero/inf/max-finite, NaNs, sign-inject, raw pass) and accumulates sticky fflags.
module pa_fpu_special_pipe #(
    parameter int FLEN  = 32,
    parameter int DEPTH = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    pa_fpu_special_pipe_if.slave  bus
);
    typedef struct packed {
        logic            dbl;
        logic [FLEN-1:0] src;
        logic [6:0]      sel;
        logic [3:0]      sign;
        logic [4:0]      ff;
    } stage_t;

    stage_t               cap;
    stage_t [DEPTH:1]     stg_d, stg_q;
    logic   [DEPTH:1]     vld_d, vld_q;
    logic   [4:0]         acc_d, acc_q;

    stage_t               o;
    logic   [63:0]        s64, r64, res64;
    logic   [31:0]        r32;
    logic                 hit, need_box, boxed_ok, wb;

    always_comb begin
        cap      = '0;
        cap.dbl  = (FLEN == 64) && bus.ex1_double;
        case (bus.ex1_src_idx)
            2'd0:    cap.src = bus.ex1_srcf0;
            2'd1:    cap.src = bus.ex1_srcf1;
            default: cap.src = bus.ex1_srcf2;
        endcase
        cap.sel  = bus.ex1_special_sel;
        cap.sign = bus.ex1_special_sign;
        cap.ff   = bus.ex1_fflags;

        vld_d = vld_q;
        stg_d = stg_q;
        acc_d = acc_q;
        if (!bus.pipe_stall) begin
            vld_d[1] = bus.ex1_inst_vld;
            stg_d[1] = cap;
            for (int k = 2; k <= DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                stg_d[k] = stg_q[k-1];
            end
            // The output-stage instruction is consumed on every unstalled edge.
            if (vld_q[DEPTH])
                acc_d = (bus.acc_clr ? 5'b0 : acc_q) | stg_q[DEPTH].ff;
            else if (bus.acc_clr)
                acc_d = 5'b0;
        end
        if (bus.pipe_flush)
            vld_d = '0;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            vld_q <= '0;
            acc_q <= '0;
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
        end
    end

    // Payload needs no reset: every output is gated by the stage valid bit.
    always_ff @(posedge forever_cpuclk) begin
        stg_q <= stg_d;
    end

    always_comb begin
        o        = stg_q[DEPTH];
        s64      = 64'(o.src);
        hit      = 1'b1;
        need_box = 1'b0;
        r32      = '0;
        r64      = '0;
        case (o.sel)
            7'b0000001: begin
                r32 = {o.sign[0], s64[30:0]};
                r64 = {o.sign[0], s64[62:0]};
                need_box = 1'b1;
            end
            7'b0000010: begin
                r32 = {o.sign[1], 31'h0};
                r64 = {o.sign[1], 63'h0};
            end
            7'b0000100: begin
                r32 = {o.sign[2], 8'hFF, 23'h0};
                r64 = {o.sign[2], 11'h7FF, 52'h0};
            end
            7'b0001000: begin
                r32 = {o.sign[3], 8'hFE, 23'h7F_FFFF};
                r64 = {o.sign[3], 11'h7FE, {52{1'b1}}};
            end
            7'b0010000: begin
                r32 = 32'h7FC0_0000;
                r64 = 64'h7FF8_0000_0000_0000;
            end
            7'b0100000: begin
                r32 = {s64[31], 8'hFF, 1'b1, s64[21:0]};
                r64 = {s64[63], 11'h7FF, 1'b1, s64[50:0]};
                need_box = 1'b1;
            end
            7'b1000000: begin
                r32 = s64[31:0];
                r64 = s64;
                need_box = 1'b1;
            end
            default: hit = 1'b0;
        endcase

        // A single operand that is not NaN-boxed in a 64-bit register reads as canonical NaN.
        boxed_ok = (FLEN == 32) || (s64[63:32] == 32'hFFFF_FFFF);
        if (o.dbl)
            res64 = r64;
        else if (FLEN == 64)
            res64 = {32'hFFFF_FFFF, (need_box && !boxed_ok) ? 32'h7FC0_0000 : r32};
        else
            res64 = {32'h0, r32};

        wb             = vld_q[DEPTH] && hit;
        bus.out_vld    = vld_q[DEPTH];
        bus.out_wb     = wb;
        bus.out_data   = wb ? res64[FLEN-1:0] : '0;
        bus.out_fflags = vld_q[DEPTH] ? o.ff : 5'b0;
        bus.acc_fflags = acc_q;
    end
endmodule

// File: doc/pa_fpu_special_pipe.md
PA_FPU_SPECIAL_PIPE -- requirements
Module: pa_fpu_special_pipe

Interface
REQ-001 Parameter FLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 1, pipeline stages from EX1 capture to output; legal range 1..4.
REQ-003 forever_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 cpurst  in  1  reset; synchronous, active-high.
REQ-005 ex1_inst_vld  in  1  EX1 carries an instruction for this block.
REQ-006 pipe_stall  in  1  freezes every stage, output and accumulator.
REQ-007 pipe_flush  in  1  kills all in-flight instructions.
REQ-008 ex1_double  in  1  double-precision op; ignored (treated 0) when FLEN=32.
REQ-009 ex1_srcf0, ex1_srcf1, ex1_srcf2  in  FLEN each  source operands.
REQ-010 ex1_src_idx  in  2  operand used by pass/propagate selects (0,1,2; 3 selects srcf2).
REQ-011 ex1_special_sel  in  7  one-hot: [0] sign-inject src, [1] zero, [2] inf, [3] largest finite, [4] canonical NaN, [5] quieted NaN of src, [6] raw src pass.
REQ-012 ex1_special_sign  in  4  signs for sel[0..3].
REQ-013 ex1_fflags  in  5  {NV,DZ,OF,UF,NX} for this instruction.
REQ-014 acc_clr  in  1  clears sticky flag accumulator.
REQ-015 out_vld  out  1  output stage holds a live instruction.
REQ-016 out_wb  out  1  out_vld and special result valid.
REQ-017 out_data  out  FLEN  special result.
REQ-018 out_fflags  out  5  flags of output instruction.
REQ-019 acc_fflags  out  5  sticky OR of consumed flags.

Function
REQ-020 Capture: when ex1_inst_vld and !pipe_stall and !pipe_flush, stage 1 SHALL latch valid, double, selected source, sel, sign, fflags; otherwise stage-1 valid SHALL be 0 unless stalled.
REQ-021 Each stage k+1 SHALL load from stage k when !pipe_stall; out_* reflect stage DEPTH; latency exactly DEPTH cycles.
REQ-022 pipe_stall SHALL hold all stage contents unchanged; pipe_flush SHALL clear all valid bits next cycle and wins over pipe_stall and ex1_inst_vld.
REQ-023 Single results (S): sel[0] {sign,src[30:0]}; sel[1] {sign,31'h0}; sel[2] {sign,8'hFF,23'h0}; sel[3] {sign,8'hFE,23'h7FFFFF}; sel[4] 32'h7FC00000; sel[5] {src[31],8'hFF,1,src[21:0]}; sel[6] src[31:0].
REQ-024 Double results (D) SHALL be the 64-bit analogues (exp 11 bits, mantissa 52, canonical NaN 64'h7FF8000000000000, quiet bit src[51]).
REQ-025 When FLEN=64 and op single, out_data[63:32] SHALL be all ones (NaN-boxed).
REQ-026 When FLEN=64, op single and selected source [63:32] not all ones, sel[0], sel[5], sel[6] SHALL produce boxed canonical NaN 0xFFFFFFFF7FC00000.
REQ-027 sel zero or multi-hot: out_wb=0, out_data=0; out_fflags still passed.
REQ-028 out_wb, out_data, out_fflags SHALL be 0 whenever out_vld=0.
REQ-029 Accumulator: when out_vld and !pipe_stall, acc_fflags <= (acc_clr ? 0 : acc_fflags) | out_fflags; acc_clr alone clears to 0 next cycle; stall blocks acc_clr too.

Reset
REQ-030 cpurst SHALL clear all valid bits and acc_fflags to 0 next edge, overriding stall, flush and capture; out_vld, out_wb, out_data, out_fflags, acc_fflags all 0 after reset.
REQ-031 Reset mid-operation SHALL discard in-flight instructions; no accumulator update from them.

Verification
REQ-032 FLEN=32, DEPTH=2: sel=7'b0000100, sign[2]=1, ex1_inst_vld one cycle -> two cycles later out_wb=1, out_data=0xFF800000, then out_vld=0.
REQ-033 FLEN=64, single, sel[5], src0=0xFFFFFFFF7F812345, idx=0 -> out_data=0xFFFFFFFF7FC12345; same with src0=0x000000007F812345 -> 0xFFFFFFFF7FC00000.
REQ-034 FLEN=64, double, sel[3], sign[3]=0 -> out_data=0x7FEFFFFFFFFFFFFF.
REQ-035 DEPTH=3, back-to-back three instructions, pipe_stall high 2 cycles at cycle 2 -> outputs appear in order, each delayed 2 cycles, acc_fflags updated once per instruction.
REQ-036 fflags 5'b10000 then 5'b00001 consumed -> acc_fflags=5'b10001; acc_clr with third instruction flags 5'b00100 consumed -> acc_fflags=5'b00100.
REQ-037 pipe_flush with pipeline full, and cpurst asserted while stalled -> out_vld=0 next cycle, acc_fflags unchanged (flush) / 0 (reset).
